bcd_display_controller: RTL
===========================

# bcd_display_controller

Frame-synchronous scheduler for the on-screen 7-segment digit renderer. Holds an NDIGITS-wide BCD counter, advances it once every FRAMES_PER_TICK video frames, and, per pixel, selects which stored digit feeds `seven_segment_decoder` along with the glyph column/row for `segments_to_bitmap`. The counter is updated only at frame start, so digits never change mid-frame. Sits between `hvsync_generator` and the decoder/bitmap pair, on the 25 MHz pixel clock.

## Interface
- NDIGITS, 4, number of BCD digits, 1..8
- FRAMES_PER_TICK, 60, frames per count increment, >=1
- XORG, 64, hpos of left edge of digit field
- YORG, 32, vpos of top edge of digit field
- clk  input  1  pixel clock (clk25)
- reset  input  1  asynchronous, active-low reset
- hpos  input  10  current pixel x from hvsync_generator
- vpos  input  10  current pixel y from hvsync_generator
- run  input  1  1 = counting enabled, 0 = paused; sampled at frame start only
- clear  input  1  request counter clear; one-cycle pulse, latched until next frame start
- digit  output  4  BCD digit for the decoder; 4'hF = blank
- col  output  3  glyph column (bitmap x offset, 0..7)
- row  output  3  glyph line (bitmap `line`, 0..7)
- in_field  output  1  pixel lies inside the digit field
- count_bcd  output  4*NDIGITS  current counter value, digit 0 in bits [3:0]
- wrap  output  1  one-cycle pulse when counter rolls from all-9s to 0

## Operation
- Frame start: cycle where hpos==0 && vpos==0 (combinational `fs`).
- Frame divider frame_cnt, width clog2(FRAMES_PER_TICK), range 0..FRAMES_PER_TICK-1.
- At fs, in priority order:
  - clear_pending==1: all digits 0, frame_cnt 0, clear_pending cleared, no wrap.
  - else run==1 and frame_cnt==FRAMES_PER_TICK-1: frame_cnt 0, counter +1 in BCD.
  - else run==1: frame_cnt+1.
  - else (paused): frame_cnt and digits hold.
- BCD increment: digit 0 +1; any digit at 9 becomes 0 and carries to the next. All NDIGITS at 9 -> all 0 and wrap=1 for that cycle.
- clear asserted any cycle sets clear_pending; clear on the fs cycle itself is applied immediately (clear_pending and fs both true in effect).
- Pixel scheduling, rel_x = hpos-XORG, rel_y = vpos-YORG (10-bit):
  - in_field = hpos>=XORG && hpos<XORG+16*NDIGITS && vpos>=YORG && vpos<YORG+16.
  - cell = rel_x[9:4]; cell 0 (leftmost) shows digit NDIGITS-1 (most significant).
  - col = rel_x[3:1], row = rel_y[3:1] (2x pixel scaling; rows 5..7 render blank via the bitmap).
  - Leading-zero blanking: digit k shows 4'hF if k>0 and digits k..NDIGITS-1 are all 0; digit 0 always shown.
  - Outside field: digit=4'hF, col=0, row=0, in_field=0.

## Timing
- digit, col, row, in_field registered: one-cycle latency from hpos/vpos. Downstream aligns display_on by one register.
- count_bcd reflects the updated value the cycle after fs; stable for the rest of the frame.
- wrap asserted in the cycle after fs, exactly one cycle.
- Reset (asynchronous, any time incl. mid-frame): digits 0, frame_cnt 0, clear_pending 0, digit=4'hF, col=0, row=0, in_field=0, wrap=0, count_bcd=0. First increment occurs at the FRAMES_PER_TICK-th fs after reset release with run=1.
- FRAMES_PER_TICK=1: increment on every fs with run=1.
- run toggling between frame starts has no effect; only the fs-cycle value counts.

## Test plan
- Reset then run=1, FRAMES_PER_TICK=2, NDIGITS=4: after 2 frames count_bcd=16'h0001; after 20 frames 16'h0010 (carry 9->10).
- Preload via 9999 increments (or force) to 16'h9999, next tick -> 16'h0000, wrap high exactly one cycle after fs.
- count 16'h0042, scan row YORG+4: cells 0,1 give digit=F, cell 2 digit=4, cell 3 digit=2; col steps 0..7 every 2 pixels; row=2; in_field 0 at hpos=XORG-1 and XORG+64.
- Pulse clear mid-frame at count 16'h0123: count_bcd stays 0123 until next fs, then 0000; frame_cnt restarts (next increment 2 frames later).
- run=0 at fs for 5 frames: count and frame_cnt frozen; run pulsed high only between fs cycles: no increment.
- Assert reset low mid-field: all outputs return to reset values asynchronously; count 0 after release.

Source files
------------

// File: rtl/bcd_display_controller.sv
// bcd_display_controller: frame-synchronous BCD counter with per-pixel digit/glyph scheduling
// for a 7-segment decoder and bitmap renderer.
module bcd_display_controller #(
    parameter int NDIGITS = 4,
    parameter int FRAMES_PER_TICK = 60,
    parameter int XORG = 64,
    parameter int YORG = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic                   run,
    input  logic                   clear,
    output logic [3:0]             digit,
    output logic [2:0]             col,
    output logic [2:0]             row,
    output logic                   in_field,
    output logic [4*NDIGITS-1:0]   count_bcd,
    output logic                   wrap
);
    localparam int FW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [FW-1:0] LAST = FW'(FRAMES_PER_TICK - 1);
    localparam logic [10:0] X0 = 11'(XORG);
    localparam logic [10:0] X1 = 11'(XORG + 16*NDIGITS);
    localparam logic [10:0] Y0 = 11'(YORG);
    localparam logic [10:0] Y1 = 11'(YORG + 16);

    logic                 fs, carry, inf, zero_run;
    logic [FW-1:0]        frame_cnt;
    logic                 clear_pending;
    logic [4*NDIGITS-1:0] cnt_inc;
    logic [NDIGITS-1:0]   blank;
    logic [9:0]           rel_x, rel_y;
    logic [2:0]           idx;
    logic [3:0]           sel;

    assign fs    = hpos == 10'd0 && vpos == 10'd0;
    assign rel_x = hpos - 10'(XORG);
    assign rel_y = vpos - 10'(YORG);
    assign inf   = {1'b0, hpos} >= X0 && {1'b0, hpos} < X1 && {1'b0, vpos} >= Y0 && {1'b0, vpos} < Y1;
    assign idx   = 3'(NDIGITS - 1) - rel_x[6:4];

    // Ripple BCD increment; carry out of the top digit means all digits were 9.
    always_comb begin
        cnt_inc = count_bcd;
        carry = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (carry) begin
                cnt_inc[4*i +: 4] = count_bcd[4*i +: 4] == 4'd9 ? 4'd0 : count_bcd[4*i +: 4] + 4'd1;
                carry = count_bcd[4*i +: 4] == 4'd9;
            end
        end
    end

    always_comb begin
        zero_run = 1'b1;
        blank = '0;
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && count_bcd[4*k +: 4] == 4'd0;
            blank[k] = (k > 0) && zero_run;
        end
    end

    always_comb begin
        sel = 4'hF;
        for (int k = 0; k < NDIGITS; k++)
            if (idx == 3'(k) && !blank[k]) sel = count_bcd[4*k +: 4];
    end

    // A clear arriving on the frame-start cycle itself takes effect immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_bcd <= '0;
            frame_cnt <= '0;
            clear_pending <= 1'b0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (fs) begin
                if (clear_pending || clear) begin
                    count_bcd <= '0;
                    frame_cnt <= '0;
                    clear_pending <= 1'b0;
                end else if (run && frame_cnt == LAST) begin
                    count_bcd <= cnt_inc;
                    frame_cnt <= '0;
                    wrap <= carry;
                end else if (run) begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end else if (clear) begin
                clear_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= 4'hF;
            col <= '0;
            row <= '0;
            in_field <= 1'b0;
        end else begin
            digit <= inf ? sel : 4'hF;
            col <= inf ? rel_x[3:1] : 3'd0;
            row <= inf ? rel_y[3:1] : 3'd0;
            in_field <= inf;
        end
    end
endmodule
